instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 24 ++
 rtl/fetch_pc.sv | 43 ++++
 rtl/instruction_fetch.sv | 97 +++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared instruction-set definitions: opcode values and instruction field positions.
// Used by the fetch stage and anything else that decodes instruction words.
package instruction_fetch_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_STO = 4'h1;
   localparam logic [3:0] OP_MUL = 4'h2;
   localparam logic [3:0] OP_LED = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;

   localparam int OPCODE_MSB = 27;
   localparam int OPCODE_LSB = 24;
   localparam int TARGET_MSB = 15;
   localparam int TARGET_LSB = 0;

   function automatic logic [3:0] insn_opcode(input logic [27:0] insn);
      return insn[OPCODE_MSB:OPCODE_LSB];
   endfunction

   function automatic logic [15:0] insn_target(input logic [27:0] insn);
      return insn[TARGET_MSB:TARGET_LSB];
   endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register and next-PC selection (redirect, early jump, increment).
module fetch_pc #(
   parameter int                    ADDR_WIDTH   = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iRedirect,
   input  logic [ADDR_WIDTH-1:0] iRedirectTarget,
   input  logic                  iLoad,
   input  logic                  iEarlyJmp,
   input  logic [ADDR_WIDTH-1:0] iJmpTarget,
   output logic [ADDR_WIDTH-1:0] oPc
);

   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_d;

   // Redirect outranks everything; the PC only advances when the IR loads.
   always_comb begin
      pc_d = pc_q;
      if (iRedirect) begin
         pc_d = iRedirectTarget;
      end else if (iLoad) begin
         if (iEarlyJmp) begin
            pc_d = iJmpTarget;
         end else begin
            pc_d = pc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign oPc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: IR with valid/ready handshake, redirect flush and accepted-count.
// Define FETCH_EARLY_JMP_EN to let a fetched JMP steer the PC with no bubble.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 16,
   parameter int                    INSN_WIDTH   = 28,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                  Clock,
   input  logic                  Reset,
   output logic [ADDR_WIDTH-1:0] oAddress,
   input  logic [INSN_WIDTH-1:0] iInstruction,
   input  logic                  iRedirect,
   input  logic [ADDR_WIDTH-1:0] iRedirectTarget,
   output logic [INSN_WIDTH-1:0] oInstruction,
   output logic [ADDR_WIDTH-1:0] oInstructionPC,
   output logic                  oValid,
   input  logic                  iReady,
   output logic [15:0]           oFetchCount
);

   logic [INSN_WIDTH-1:0] ir_q, ir_d;
   logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
   logic                  valid_q, valid_d;
   logic [15:0]           count_q, count_d;

   logic                  transfer;
   logic                  load;
   logic                  jmp_taken;
   logic [ADDR_WIDTH-1:0] jmp_target;
   logic [ADDR_WIDTH-1:0] pc;

   assign transfer = valid_q & iReady;
   assign load     = ~valid_q | transfer;

`ifdef FETCH_EARLY_JMP_EN
   assign jmp_taken  = load && (insn_opcode(iInstruction) == OP_JMP);
   assign jmp_target = ADDR_WIDTH'(insn_target(iInstruction));
`else
   assign jmp_taken  = 1'b0;
   assign jmp_target = '0;
`endif

   fetch_pc #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .RESET_VECTOR (RESET_VECTOR)
   ) u_fetch_pc (
      .Clock           (Clock),
      .Reset           (Reset),
      .iRedirect       (iRedirect),
      .iRedirectTarget (iRedirectTarget),
      .iLoad           (load),
      .iEarlyJmp       (jmp_taken),
      .iJmpTarget      (jmp_target),
      .oPc             (pc)
   );

   // An instruction accepted on the redirect edge still counts; only the held, unaccepted one is dropped.
   always_comb begin
      ir_d    = ir_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;
      count_d = count_q;
      if (transfer && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
      if (iRedirect) begin
         valid_d = 1'b0;
      end else if (load) begin
         ir_d    = iInstruction;
         ipc_d   = pc;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         ir_q    <= '0;
         ipc_q   <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         ir_q    <= ir_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign oAddress       = pc;
   assign oInstruction   = ir_q;
   assign oInstructionPC = ipc_q;
   assign oValid         = valid_q;
   assign oFetchCount    = count_q;

endmodule
